// File: rtl/adc2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc2s_pkg
//  Description : Shared types and helpers for the two-stage ADC conversion
//                sequencer (FSM state encoding, default code widths, phase
//                counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package adc2s_pkg;

    // Default stage code widths
    localparam int c_MSB_W = 3;
    localparam int c_LSB_W = 3;

    // Conversion FSM states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CONV1  = 3'd2,
        SETTLE = 3'd3,
        CONV2  = 3'd4
    } state_e;

    // Bits needed to hold the longest phase length (loads are T-1, so this
    // leaves a spare code; at least one bit)
    function automatic int cnt_width(input int a, input int b,
                                     input int c, input int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= m) w = i + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc2s_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : adc2s_phase_timer
//  Description : Loadable down-counter that times one conversion phase.
//                done_o is high while the count is zero; the count holds at
//                zero until the next load.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc2s_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Load on phase entry, otherwise count down to zero and hold
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= value_i;
        end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign count_o = r_count;
    assign done_o  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/adc2s_conv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : adc2s_conv_seq
//  Description : Conversion sequencer for a two-stage subranging ADC front
//                end. Generates track/hold, stage-1 latch, residue-DAC load
//                and stage-2 latch strobes, aligns the {MSB, LSB} result and
//                presents it on a valid/ready output with sticky overrun.
//                Optional build macro ADC2S_OVR_CNT_EN adds ovr_cnt_o, a
//                saturating 8-bit overrun event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc2s_conv_seq
    import adc2s_pkg::*;
#(
    parameter int MSB_W    = c_MSB_W,
    parameter int LSB_W    = c_LSB_W,
    parameter int T_SAMPLE = 2,
    parameter int T_CONV1  = 1,
    parameter int T_SETTLE = 2,
    parameter int T_CONV2  = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic                   cont_i,
    input  logic [MSB_W-1:0]       msb_i,
    input  logic [LSB_W-1:0]       lsb_i,
    input  logic                   ready_i,
    input  logic                   clr_ovr_i,
    output logic                   sample_o,
    output logic                   latch1_o,
    output logic                   dac_load_o,
    output logic [MSB_W-1:0]       dac_code_o,
    output logic                   latch2_o,
    output logic [MSB_W+LSB_W-1:0] dout_o,
    output logic                   valid_o,
    output logic                   busy_o,
`ifdef ADC2S_OVR_CNT_EN
    output logic [7:0]             ovr_cnt_o,
`endif
    output logic                   overrun_o
);

    localparam int c_CW = cnt_width(T_SAMPLE, T_CONV1, T_SETTLE, T_CONV2);

    // Timer load values: a phase of T cycles counts T-1 .. 0
    localparam logic [c_CW-1:0] c_LD_SAMPLE = c_CW'(T_SAMPLE - 1);
    localparam logic [c_CW-1:0] c_LD_CONV1  = c_CW'(T_CONV1 - 1);
    localparam logic [c_CW-1:0] c_LD_SETTLE = c_CW'(T_SETTLE - 1);
    localparam logic [c_CW-1:0] c_LD_CONV2  = c_CW'(T_CONV2 - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    state_e                   r_state;
    logic                     r_sample;
    logic                     r_busy;
    logic                     r_latch1;
    logic                     r_dac_load;
    logic                     r_latch2;
    logic [MSB_W-1:0]         r_msb;
    logic [MSB_W+LSB_W-1:0]   r_dout;
    logic                     r_valid;
    logic                     r_overrun;

    state_e                   w_state_nxt;
    logic                     w_load;
    logic [c_CW-1:0]          w_load_val;
    logic [c_CW-1:0]          w_count;
    logic                     w_done;
    logic                     w_last_nxt;
    logic                     w_cap_msb;
    logic                     w_cap_res;
    logic                     w_ovr_set;

    adc2s_phase_timer #(
        .CNT_W (c_CW)
    ) u_phase_timer (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   (w_load),
        .value_i  (w_load_val),
        .count_o  (w_count),
        .done_o   (w_done)
    );

    // Next-state, timer load and capture decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_cap_msb   = 1'b0;
        w_cap_res   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i || cont_i) begin
                    w_state_nxt = SAMPLE;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_done) begin
                    w_state_nxt = CONV1;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_CONV1;
                end
            end
            CONV1: begin
                if (w_done) begin
                    w_cap_msb   = 1'b1;
                    w_state_nxt = SETTLE;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_SETTLE;
                end
            end
            SETTLE: begin
                if (w_done) begin
                    w_state_nxt = CONV2;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_CONV2;
                end
            end
            CONV2: begin
                if (w_done) begin
                    w_cap_res = 1'b1;
                    if (cont_i) begin
                        w_state_nxt = SAMPLE;
                        w_load      = 1'b1;
                        w_load_val  = c_LD_SAMPLE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next cycle is the final cycle of its phase; strobes are registered so
    // they must be decided one cycle ahead from the upcoming count
    assign w_last_nxt = w_load ? (w_load_val == '0) : (w_count == c_CNT_ONE);

    // Sequencer FSM with registered strobe outputs and MSB capture
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= IDLE;
            r_sample   <= 1'b1;
            r_busy     <= 1'b0;
            r_latch1   <= 1'b0;
            r_dac_load <= 1'b0;
            r_latch2   <= 1'b0;
            r_msb      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sample   <= (w_state_nxt == IDLE) || (w_state_nxt == SAMPLE);
            r_busy     <= (w_state_nxt != IDLE);
            r_latch1   <= (w_state_nxt == CONV1) && w_last_nxt;
            r_dac_load <= (w_state_nxt == SETTLE) && w_load;
            r_latch2   <= (w_state_nxt == CONV2) && w_last_nxt;
            if (w_cap_msb) begin
                r_msb <= msb_i;
            end
        end
    end

    // A fresh result overwriting an unconsumed one is an overrun
    assign w_ovr_set = w_cap_res && r_valid && !ready_i;

    // Result register, valid/ready handshake and sticky overrun flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_cap_res) begin
                r_dout  <= {r_msb, lsb_i};
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef ADC2S_OVR_CNT_EN
    logic [7:0] r_ovr_cnt;

    // Saturating overrun event counter; an event in the clear cycle counts 1
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ovr_cnt <= 8'd0;
        end else if (w_ovr_set) begin
            if (clr_ovr_i) begin
                r_ovr_cnt <= 8'd1;
            end else if (r_ovr_cnt != 8'hFF) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
        end else if (clr_ovr_i) begin
            r_ovr_cnt <= 8'd0;
        end
    end

    assign ovr_cnt_o = r_ovr_cnt;
`endif

    assign sample_o   = r_sample;
    assign busy_o     = r_busy;
    assign latch1_o   = r_latch1;
    assign dac_load_o = r_dac_load;
    assign latch2_o   = r_latch2;
    assign dac_code_o = r_msb;
    assign dout_o     = r_dout;
    assign valid_o    = r_valid;
    assign overrun_o  = r_overrun;

endmodule
`default_nettype wire
